// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS responder interface for the timer peripheral.
// Signals:
//   addr   32  byte address from the MCU
//   wdata  32  store data from the MCU
//   wr     1   write strobe, one write per high cycle
//   rdata  32  load data back to the MCU, combinational from the responder
// Modports: master (MCU side) drives addr/wdata/wr; slave (peripheral) drives rdata.
interface otter_iobus_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output wr,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr,
        output rdata
    );
endinterface

// File: rtl/otter_iobus_timer.sv
// Memory-mapped timer/compare peripheral on the OTTER IOBUS.
// A prescaled up-counter compared against COMPARE; a match sets a sticky MATCH flag,
// then either reloads the count to zero or stops the timer (one-shot).
// Ports:
//   clk       system clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   bus       IOBUS slave: addr/wdata/wr in, rdata out (zero-latency read)
//   tmr_intr  registered level interrupt, MATCH & IRQ_EN
// Register map (word offsets in a 32-byte window at BASE_ADDR):
//   0x00 CTRL [0]EN [1]AUTO_RELOAD [2]IRQ_EN, 0x04 PRESCALE, 0x08 COMPARE,
//   0x0C COUNT, 0x10 STATUS [0]MATCH (write 1 to clear); other offsets read 0.
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int unsigned PRE_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    otter_iobus_timer_if.slave   bus,
    output logic                 tmr_intr
);

    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffPrescale = 3'd1;
    localparam logic [2:0] OffCompare  = 3'd2;
    localparam logic [2:0] OffCount    = 3'd3;
    localparam logic [2:0] OffStatus   = 3'd4;

    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             irq_en_q, irq_en_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      count_q, count_d;
    logic             match_q, match_d;
    logic             intr_q, intr_d;

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       tick;
    logic       match_set;
    logic       stop;
    logic [31:0] rdata;

    // Word access only: the byte lane bits are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^bus.addr[1:0];

    always_comb begin
        hit         = bus.addr[31:5] == BASE_ADDR[31:5];
        off         = bus.addr[4:2];
        wr_ctrl     = bus.wr && hit && (off == OffCtrl);
        wr_prescale = bus.wr && hit && (off == OffPrescale);
        wr_compare  = bus.wr && hit && (off == OffCompare);
        wr_count    = bus.wr && hit && (off == OffCount);
        wr_status   = bus.wr && hit && (off == OffStatus);
    end

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;
        match_set  = 1'b0;
        stop       = 1'b0;

        tick = en_q && (pre_cnt_q == prescale_q);

        if (en_q) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
        // A new prescale value or a fresh enable restarts the tick phase.
        if (wr_prescale || (wr_ctrl && !en_q && bus.wdata[0])) begin
            pre_cnt_d = '0;
        end

        // A COUNT write wins outright: no compare is evaluated this cycle.
        if (wr_count) begin
            count_d = bus.wdata;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (auto_q) begin
                    count_d = '0;
                end else begin
                    stop = 1'b1;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_ctrl) begin
            en_d     = bus.wdata[0];
            auto_d   = bus.wdata[1];
            irq_en_d = bus.wdata[2];
        end else if (stop) begin
            en_d = 1'b0;
        end

        if (wr_prescale) begin
            prescale_d = bus.wdata[PRE_W-1:0];
        end
        if (wr_compare) begin
            compare_d = bus.wdata;
        end

        // Setting beats clearing when both land in the same cycle.
        if (match_set) begin
            match_d = 1'b1;
        end else if (wr_status && bus.wdata[0]) begin
            match_d = 1'b0;
        end

        intr_d = match_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            count_q    <= '0;
            match_q    <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            intr_q     <= intr_d;
        end
    end

    // Reads see the pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OffCtrl:     rdata = {29'd0, irq_en_q, auto_q, en_q};
                OffPrescale: rdata = 32'(prescale_q);
                OffCompare:  rdata = compare_q;
                OffCount:    rdata = count_q;
                OffStatus:   rdata = {31'd0, match_q};
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.rdata = rdata;
    assign tmr_intr  = intr_q;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: directed scenarios with fixed expectations,
// then randomized bus traffic compared against a behavioural model of the register rules.
module tb_otter_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STS  = BASE + 32'h10;

    logic clk;
    logic rst_n;
    logic tmr_intr;

    otter_iobus_timer_if bus ();

    otter_iobus_timer #(
        .BASE_ADDR (BASE),
        .PRE_W     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .tmr_intr (tmr_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic        m_en, m_auto, m_irq, m_match, m_intr;
    logic [15:0] m_pre, m_pcnt;
    logic [31:0] m_cmp, m_cnt;

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_irq = 0; m_match = 0; m_intr = 0;
        m_pre = 0; m_pcnt = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return {29'd0, m_irq, m_auto, m_en};
            3'd1: return {16'd0, m_pre};
            3'd2: return m_cmp;
            3'd3: return m_cnt;
            3'd4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    // Apply one clock edge worth of the register rules to the model.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w);
        logic        is_tick, hitm, cmp_eq;
        logic        n_en, n_auto, n_irq, n_match;
        logic [15:0] n_pre, n_pcnt;
        logic [31:0] n_cmp, n_cnt;
        hitm    = (a[31:5] == BASE[31:5]);
        is_tick = m_en && (m_pcnt == m_pre);
        cmp_eq  = is_tick && (m_cnt == m_cmp);
        n_en = m_en; n_auto = m_auto; n_irq = m_irq; n_match = m_match;
        n_pre = m_pre; n_cmp = m_cmp; n_cnt = m_cnt;
        n_pcnt = m_en ? (is_tick ? 16'd0 : m_pcnt + 16'd1) : m_pcnt;
        if (is_tick) begin
            if (cmp_eq) begin
                n_match = 1;
                if (m_auto) n_cnt = 0;
                else n_en = 0;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        if (w && hitm) begin
            case (a[4:2])
                3'd0: begin
                    if (!m_en && d[0]) n_pcnt = 0;
                    n_en = d[0]; n_auto = d[1]; n_irq = d[2];
                end
                3'd1: begin n_pre = d[15:0]; n_pcnt = 0; end
                3'd2: n_cmp = d;
                3'd3: begin n_cnt = d; n_match = m_match; n_en = m_en; end
                3'd4: if (d[0] && !cmp_eq) n_match = 0;
                default: ;
            endcase
        end
        m_en = n_en; m_auto = n_auto; m_irq = n_irq; m_match = n_match;
        m_pre = n_pre; m_pcnt = n_pcnt; m_cmp = n_cmp; m_cnt = n_cnt;
        m_intr = n_match && n_irq;
    endtask

    // Advance one clock edge; ends 1 time unit after the edge.
    task automatic step();
        model_step(bus.addr, bus.wdata, bus.wr);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        bus.wr = 1'b0;
        bus.addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic reset_dut();
        bus.wr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        peek(A_CTRL, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got=%h want=%h", v, 32'd0); end
        n_checks++;
        peek(A_PRE, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_pre got=%h want=%h", v, 32'd0); end
        n_checks++;
        peek(A_CMP, v);
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp got=%h want=ffffffff", v); end
        n_checks++;
        peek(A_STS, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL reset_sts got=%h want=0", v); end
        n_checks++;
        if (tmr_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr got=%b want=0", tmr_intr); end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        // Run the count up to 7, then drop reset mid-cycle.
        wr_reg(A_CNT, 32'd5);
        wr_reg(A_CTRL, 32'd1);
        step();
        step();
        peek(A_CNT, v);
        if (v !== 32'd7) begin n_fail++; $display("FAIL pre_reset_cnt got=%0d want=7", v); end
        n_checks++;
        #1;
        rst_n = 1'b0;
        model_reset();
        peek(A_CNT, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL async_reset_cnt got=%0d want=0", v); end
        n_checks++;
        peek(A_CMP, v);
        if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_reset_cmp got=%h want=ffffffff", v); end
        n_checks++;
        peek(A_CTRL, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL async_reset_ctrl got=%h want=0", v); end
        n_checks++;
        if (tmr_intr !== 1'b0) begin n_fail++; $display("FAIL async_reset_intr got=%b want=0", tmr_intr); end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        peek(A_CNT, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle_cnt got=%0d want=0", v); end
        n_checks++;
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        reset_dut();
        wr_reg(A_PRE, 32'd3);
        wr_reg(A_CMP, 32'd100);
        wr_reg(A_CTRL, 32'd1);
        for (int i = 1; i <= 20; i++) begin
            step();
            peek(A_CNT, v);
            if (v !== 32'(i / 4)) begin
                n_fail++; $display("FAIL prescale_cnt clk=%0d got=%0d want=%0d", i, v, i / 4);
            end
            n_checks++;
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        reset_dut();
        wr_reg(A_PRE, 32'd0);
        wr_reg(A_CMP, 32'd4);
        wr_reg(A_CTRL, 32'd5);
        repeat (4) step();
        peek(A_STS, v);
        if (v !== 32'd0 || tmr_intr !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_before_match sts=%0d intr=%b want sts=0 intr=0", v, tmr_intr);
        end
        n_checks++;
        step();
        peek(A_STS, v);
        if (v !== 32'd1) begin n_fail++; $display("FAIL oneshot_match got=%0d want=1", v); end
        n_checks++;
        if (tmr_intr !== 1'b1) begin n_fail++; $display("FAIL oneshot_intr got=%b want=1", tmr_intr); end
        n_checks++;
        step();
        step();
        peek(A_CNT, v);
        if (v !== 32'd4) begin n_fail++; $display("FAIL oneshot_hold got=%0d want=4", v); end
        n_checks++;
        peek(A_CTRL, v);
        if (v !== 32'd4) begin n_fail++; $display("FAIL oneshot_ctrl got=%0d want=4", v); end
        n_checks++;
        wr_reg(A_STS, 32'd0);
        if (tmr_intr !== 1'b1) begin n_fail++; $display("FAIL sts_write0 intr=%b want=1", tmr_intr); end
        n_checks++;
        wr_reg(A_STS, 32'd1);
        if (tmr_intr !== 1'b0) begin n_fail++; $display("FAIL sts_clear intr=%b want=0", tmr_intr); end
        n_checks++;
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        reset_dut();
        wr_reg(A_CMP, 32'd2);
        wr_reg(A_PRE, 32'd0);
        wr_reg(A_CTRL, 32'd3);
        for (int k = 1; k <= 6; k++) begin
            step();
            peek(A_CNT, v);
            if (v !== 32'(k % 3)) begin
                n_fail++; $display("FAIL reload_cnt k=%0d got=%0d want=%0d", k, v, k % 3);
            end
            n_checks++;
        end
        peek(A_STS, v);
        if (v !== 32'd1) begin n_fail++; $display("FAIL reload_sticky got=%0d want=1", v); end
        n_checks++;
        if (tmr_intr !== 1'b0) begin n_fail++; $display("FAIL reload_intr got=%b want=0", tmr_intr); end
        n_checks++;
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        reset_dut();
        wr_reg(A_PRE, 32'd0);
        wr_reg(A_CMP, 32'd3);
        wr_reg(A_CTRL, 32'd1);
        repeat (3) step();
        wr_reg(A_STS, 32'd1);
        peek(A_STS, v);
        if (v !== 32'd1) begin n_fail++; $display("FAIL match_beats_clear got=%0d want=1", v); end
        n_checks++;
        wr_reg(A_CMP, 32'd100);
        wr_reg(A_CTRL, 32'd1);
        wr_reg(A_CNT, 32'd9);
        peek(A_CNT, v);
        if (v !== 32'd9) begin n_fail++; $display("FAIL cnt_write_on_tick got=%0d want=9", v); end
        n_checks++;
        step();
        peek(A_CNT, v);
        if (v !== 32'd10) begin n_fail++; $display("FAIL cnt_after_write got=%0d want=10", v); end
        n_checks++;
    endtask

    task automatic test_wrap_decode();
        logic [31:0] v;
        reset_dut();
        wr_reg(A_CNT, 32'hFFFF_FFFF);
        wr_reg(A_CMP, 32'd5);
        wr_reg(A_CTRL, 32'd1);
        step();
        peek(A_CNT, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt got=%h want=0", v); end
        n_checks++;
        peek(A_STS, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_no_match got=%0d want=0", v); end
        n_checks++;
        wr_reg(BASE + 32'h20, 32'hFFFF_FFFF);
        peek(A_CTRL, v);
        if (v !== 32'd1) begin n_fail++; $display("FAIL miss_ctrl got=%h want=1", v); end
        n_checks++;
        peek(A_CMP, v);
        if (v !== 32'd5) begin n_fail++; $display("FAIL miss_cmp got=%h want=5", v); end
        n_checks++;
        peek(A_PRE, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL miss_pre got=%h want=0", v); end
        n_checks++;
        peek(BASE + 32'h14, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL read_off14 got=%h want=0", v); end
        n_checks++;
        peek(BASE + 32'h20, v);
        if (v !== 32'd0) begin n_fail++; $display("FAIL read_miss got=%h want=0", v); end
        n_checks++;
        peek(BASE + 32'h0B, v);
        if (v !== 32'd5) begin n_fail++; $display("FAIL byte_lane_ignored got=%h want=5", v); end
        n_checks++;
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp;
        int unsigned off;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            off = $urandom % 8;
            a = BASE + 32'(off * 4) + 32'($urandom % 4);
            if ($urandom % 16 == 0) a = a ^ (32'd1 << (5 + $urandom % 27));
            case (off)
                0: d = $urandom;
                1: d = ($urandom & 32'hFFFC_0000) | 32'($urandom % 4);
                2: d = 32'($urandom % 12);
                3: d = ($urandom % 20 == 0) ? 32'hFFFF_FFFF : 32'($urandom % 12);
                default: d = $urandom;
            endcase
            bus.addr  = a;
            bus.wdata = d;
            bus.wr    = ($urandom % 3 == 0);
            if (off == 0 && bus.wr && $urandom % 2 == 0) d[0] = 1'b1;
            bus.wdata = d;
            #1;
            exp = m_read(a);
            if (bus.rdata !== exp) begin
                n_fail++; $display("FAIL rand_read i=%0d addr=%h got=%h want=%h", i, a, bus.rdata, exp);
            end
            n_checks++;
            if (tmr_intr !== m_intr) begin
                n_fail++; $display("FAIL rand_intr i=%0d got=%b want=%b", i, tmr_intr, m_intr);
            end
            n_checks++;
            step();
        end
        bus.wr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        bus.wr    = 1'b0;
        model_reset();
        #3;
        test_reset();
        test_prescale();
        test_one_shot();
        test_auto_reload();
        test_collisions();
        test_wrap_decode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

endmodule
